tmr_triplicator: RTL

TMR_TRIPLICATOR -- requirements
Module: tmr_triplicator

---
 rtl/tmr_triplicator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tmr_triplicator.sv
// Triple-redundant register with a periodic majority-vote scrubber that repairs a diverged copy.
// Optional fault injection ports are compiled in with `define TMR_FAULT_INJECT_EN.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | accepting writes, scrub timer counting toward SCRUB_PERIOD-1
// ST_VOTE      | capture bitwise majority of A/B/C and whether any copy differs
// ST_WRITEBACK | repair all copies from the vote if a mismatch was captured
module tmr_triplicator #(
    parameter int WIDTH        = 8,
    parameter int SCRUB_PERIOD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef TMR_FAULT_INJECT_EN
    input  logic             inj_valid,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
`endif
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             err_flag,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_VOTE      = 2'd1,
        ST_WRITEBACK = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(SCRUB_PERIOD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_timer;
    logic [WIDTH-1:0] r_copy_a;
    logic [WIDTH-1:0] r_copy_b;
    logic [WIDTH-1:0] r_copy_c;
    logic [WIDTH-1:0] r_voted;
    logic             r_mismatch;
    logic [7:0]       r_err_count;

    logic             w_accept;
    logic             w_correct;
    logic [WIDTH-1:0] w_voted;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_copy_a_nxt;
    logic [WIDTH-1:0] w_copy_b_nxt;
    logic [WIDTH-1:0] w_copy_c_nxt;

    assign w_voted    = (r_copy_a & r_copy_b) | (r_copy_a & r_copy_c) | (r_copy_b & r_copy_c);
    assign w_mismatch = (r_copy_a != w_voted) || (r_copy_b != w_voted) || (r_copy_c != w_voted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending write always wins over an expiring timer.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_correct   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (!in_valid && (r_timer == TIMER_LAST)) begin
                    w_state_nxt = ST_VOTE;
                end
            end
            ST_VOTE: begin
                w_state_nxt = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_correct   = r_mismatch;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_timer <= w_accept ? 8'd0 : r_timer + 8'd1;
        end else if (r_state == ST_WRITEBACK) begin
            r_timer <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voted    <= '0;
            r_mismatch <= 1'b0;
        end else if (r_state == ST_VOTE) begin
            r_voted    <= w_voted;
            r_mismatch <= w_mismatch;
        end
    end

    // Writes and repairs overwrite all copies, so a coincident injection is dropped.
    always_comb begin
        w_copy_a_nxt = r_copy_a;
        w_copy_b_nxt = r_copy_b;
        w_copy_c_nxt = r_copy_c;
        if (w_accept) begin
            w_copy_a_nxt = in_data;
            w_copy_b_nxt = in_data;
            w_copy_c_nxt = in_data;
        end else if (w_correct) begin
            w_copy_a_nxt = r_voted;
            w_copy_b_nxt = r_voted;
            w_copy_c_nxt = r_voted;
`ifdef TMR_FAULT_INJECT_EN
        end else if (inj_valid) begin
            case (inj_sel)
                2'd0:    w_copy_a_nxt = r_copy_a ^ inj_mask;
                2'd1:    w_copy_b_nxt = r_copy_b ^ inj_mask;
                2'd2:    w_copy_c_nxt = r_copy_c ^ inj_mask;
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_copy_a <= '0;
            r_copy_b <= '0;
            r_copy_c <= '0;
        end else begin
            r_copy_a <= w_copy_a_nxt;
            r_copy_b <= w_copy_b_nxt;
            r_copy_c <= w_copy_c_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_correct && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign out_a     = r_copy_a;
    assign out_b     = r_copy_b;
    assign out_c     = r_copy_c;
    assign err_flag  = w_correct;
    assign err_count = r_err_count;

endmodule
